// File: rtl/spi_master_driver_pkg.sv
// Shared SPI definitions: FSM state encodings, word size and the default
// timing values. The slave-side bench uses the same defaults.
package spi_defs;

  localparam int SPI_WORD_BITS     = 8;
  localparam int SCLK_HALF_DEFAULT = 4;
  localparam int CS_GUARD_DEFAULT  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } spiState_t;

  // Larger of two integers, used to size the phase counter.
  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_master_driver_phase_timer.sv
// Loadable down-counter that times each FSM phase. It stops at zero and
// flags zero so the FSM knows it is in the last cycle of the phase.
module spi_phase_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  // Reload on request, otherwise count down and hold at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/spi_master_driver.sv
// CPOL=0 / CPHA=0 SPI master. One request moves one byte full-duplex,
// LSB first. MISO is sampled a full half-period after each falling edge,
// so a slave that registers its output from the same clock has slack.
module spi_master_driver
  import spi_defs::*;
#(
  parameter int SCLK_HALF = SCLK_HALF_DEFAULT,
  parameter int CS_GUARD  = CS_GUARD_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [SPI_WORD_BITS-1:0] data_in_bi,
  output logic                     ready_o,
  output logic                     done_o,
  output logic [SPI_WORD_BITS-1:0] data_out_bo,
  output logic                     spi_sclk_o,
  output logic                     spi_mosi_o,
  input  logic                     spi_miso_i,
  output logic                     spi_cs_o
);

  localparam int PHASE_W = $clog2(maxInt(SCLK_HALF, CS_GUARD) + 1);
  localparam logic [PHASE_W-1:0] HALF_LOAD  = PHASE_W'(SCLK_HALF - 1);
  localparam logic [PHASE_W-1:0] GUARD_LOAD = PHASE_W'(CS_GUARD - 1);

  spiState_t                r_state;
  spiState_t                w_nextState;
  logic [SPI_WORD_BITS-1:0] r_txShift;
  logic [SPI_WORD_BITS-1:0] r_rxShift;
  logic [3:0]               r_bitCnt;
  logic                     r_ready;
  logic                     r_done;
  logic [SPI_WORD_BITS-1:0] r_dataOut;
  logic                     r_sclk;
  logic                     r_mosi;
  logic                     r_cs;
  logic                     w_accept;
  logic                     w_phaseZero;
  logic                     w_timerLoad;
  logic [PHASE_W-1:0]       w_timerValue;

  assign w_accept = (r_state == ST_IDLE) && r_ready && start_i;

  spi_phase_timer #(.WIDTH(PHASE_W)) u_phaseTimer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_load  (w_timerLoad),
    .i_value (w_timerValue),
    .o_zero  (w_phaseZero)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  // Next state, plus the phase-timer reload on every state change.
  always_comb begin
    w_nextState  = r_state;
    w_timerValue = HALF_LOAD;
    case (r_state)
      ST_IDLE:  if (w_accept)    w_nextState = ST_SETUP;
      ST_SETUP: if (w_phaseZero) w_nextState = ST_LOW;
      ST_LOW:   if (w_phaseZero) w_nextState = ST_HIGH;
      ST_HIGH:  if (w_phaseZero)
                  w_nextState = (r_bitCnt == 4'(SPI_WORD_BITS - 1)) ? ST_HOLD : ST_LOW;
      ST_HOLD:  if (w_phaseZero) w_nextState = ST_GAP;
      ST_GAP:   if (w_phaseZero) w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
    case (w_nextState)
      ST_SETUP, ST_HOLD, ST_GAP: w_timerValue = GUARD_LOAD;
      default:                   w_timerValue = HALF_LOAD;
    endcase
    w_timerLoad = (w_nextState != r_state);
  end

  // Registered SPI lines, shift registers and handshake outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_txShift <= '0;
      r_rxShift <= '0;
      r_bitCnt  <= 4'd0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_dataOut <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs      <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_txShift <= data_in_bi;
            r_mosi    <= data_in_bi[0];
            r_bitCnt  <= 4'd0;
            r_cs      <= 1'b0;
            r_sclk    <= 1'b0;
            r_ready   <= 1'b0;
          end
        end
        ST_SETUP: begin
        end
        ST_LOW: begin
          if (w_phaseZero) begin
            r_rxShift <= {spi_miso_i, r_rxShift[SPI_WORD_BITS-1:1]};
            r_sclk    <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (w_phaseZero) begin
            r_sclk    <= 1'b0;
            r_txShift <= r_txShift >> 1;
            r_mosi    <= r_txShift[1];
            if (r_bitCnt < 4'(SPI_WORD_BITS)) r_bitCnt <= r_bitCnt + 4'd1;
          end
        end
        ST_HOLD: begin
          r_mosi <= 1'b0;
          if (w_phaseZero) begin
            r_cs      <= 1'b1;
            r_dataOut <= r_rxShift;
            r_done    <= 1'b1;
          end
        end
        ST_GAP: begin
          if (w_phaseZero) r_ready <= 1'b1;
        end
        default: begin
          r_cs    <= 1'b1;
          r_sclk  <= 1'b0;
          r_mosi  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o     = r_ready;
  assign done_o      = r_done;
  assign data_out_bo = r_dataOut;
  assign spi_sclk_o  = r_sclk;
  assign spi_mosi_o  = r_mosi;
  assign spi_cs_o    = r_cs;

endmodule

// File: tb/tb_spi_master_driver.sv
// Directed bench for spi_master_driver: two instances (default timing and
// SCLK_HALF=2/CS_GUARD=3), each wired to a small registered slave model.
// Cycle labels follow the timing description: the cycle right after the
// accepting edge T is label 1 (T+1).
module tb_spi_master_driver;
  import spi_defs::*;

  localparam int SH_A = SCLK_HALF_DEFAULT;
  localparam int CG_A = CS_GUARD_DEFAULT;
  localparam int SH_B = 2;
  localparam int CG_B = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       sel   = 1'b0;
  logic [7:0] dataIn  = 8'h00;
  logic [7:0] slaveTx = 8'h00;

  int assertCount = 0;
  int failCount   = 0;

  logic startA, readyA, doneA, sclkA, mosiA, csA;
  logic startB, readyB, doneB, sclkB, mosiB, csB;
  logic misoA = 1'b0, misoB = 1'b0;
  logic [7:0] doutA, doutB;

  always #5 clock = ~clock;

  assign startA = start & ~sel;
  assign startB = start & sel;

  spi_master_driver #(.SCLK_HALF(SH_A), .CS_GUARD(CG_A)) dutA (
    .clk_i(clock), .rst_i(reset), .start_i(startA), .data_in_bi(dataIn),
    .ready_o(readyA), .done_o(doneA), .data_out_bo(doutA),
    .spi_sclk_o(sclkA), .spi_mosi_o(mosiA), .spi_miso_i(misoA), .spi_cs_o(csA)
  );

  spi_master_driver #(.SCLK_HALF(SH_B), .CS_GUARD(CG_B)) dutB (
    .clk_i(clock), .rst_i(reset), .start_i(startB), .data_in_bi(dataIn),
    .ready_o(readyB), .done_o(doneB), .data_out_bo(doutB),
    .spi_sclk_o(sclkB), .spi_mosi_o(mosiB), .spi_miso_i(misoB), .spi_cs_o(csB)
  );

  // Slave model A: loads its byte while deselected, advances MISO one
  // cycle after it sees SCLK low, captures MOSI one cycle after SCLK rises.
  logic [7:0] shA = 8'h00, rxA = 8'h00;
  logic       pSclkA = 1'b0;
  always @(posedge clock) begin
    pSclkA <= sclkA;
    if (csA) begin
      shA   <= slaveTx;
      misoA <= slaveTx[0];
    end else begin
      if (pSclkA && !sclkA) begin
        shA   <= shA >> 1;
        misoA <= shA[1];
      end
      if (!pSclkA && sclkA) rxA <= {mosiA, rxA[7:1]};
    end
  end

  // Slave model B, identical behaviour for the second instance.
  logic [7:0] shB = 8'h00, rxB = 8'h00;
  logic       pSclkB = 1'b0;
  always @(posedge clock) begin
    pSclkB <= sclkB;
    if (csB) begin
      shB   <= slaveTx;
      misoB <= slaveTx[0];
    end else begin
      if (pSclkB && !sclkB) begin
        shB   <= shB >> 1;
        misoB <= shB[1];
      end
      if (!pSclkB && sclkB) rxB <= {mosiB, rxB[7:1]};
    end
  end

  logic       mCs, mSclk, mMosi, mReady, mDone;
  logic [7:0] mDout, mSlvRx;
  assign mCs    = sel ? csB    : csA;
  assign mSclk  = sel ? sclkB  : sclkA;
  assign mMosi  = sel ? mosiB  : mosiA;
  assign mReady = sel ? readyB : readyA;
  assign mDone  = sel ? doneB  : doneA;
  assign mDout  = sel ? doutB  : doutA;
  assign mSlvRx = sel ? rxB    : rxA;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic waitReady();
    int n;
    n = 0;
    while (!mReady && n < 400) begin
      waitCycle();
      n++;
    end
    checkOutput("readyBeforeStart", 32'(mReady), 32'h1);
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (!mDone && n < 400) begin
      waitCycle();
      n++;
    end
    checkOutput("doneSeen", 32'(mDone), 32'h1);
  endtask

  // One request; monitors the whole transfer until ready returns.
  task automatic applyStimulus(input logic [7:0] tx, input logic [7:0] slv,
                               input int pulseAt,
                               output int firstRise, output int doneLbl,
                               output int csLow, output int rises,
                               output int doneCnt, output int readyLbl,
                               output int mosiViol);
    int   lbl;
    logic pS, pC, pM;
    firstRise = 0; doneLbl = 0; csLow = 0; rises = 0;
    doneCnt = 0; readyLbl = -1; mosiViol = 0;
    slaveTx = slv;
    dataIn  = tx;
    pS = mSclk; pC = mCs; pM = mMosi;
    start = 1'b1;
    waitCycle();
    start = 1'b0;
    lbl = 1;
    while (lbl < 400) begin
      if (lbl == 2) dataIn = ~tx;
      if (pulseAt != 0 && lbl == pulseAt) start = 1'b1;
      if (pulseAt != 0 && lbl == pulseAt + 1) start = 1'b0;
      if (!mCs) csLow++;
      if (!mCs && mSclk && !pS) begin
        rises++;
        if (firstRise == 0) firstRise = lbl;
      end
      if (mMosi !== pM && !mCs && !(pS && !mSclk) && !(pC && !mCs)) mosiViol++;
      if (mDone) begin
        doneCnt++;
        doneLbl = lbl;
      end
      if (mReady) begin
        readyLbl = lbl;
        break;
      end
      pS = mSclk; pC = mCs; pM = mMosi;
      waitCycle();
      lbl++;
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fr, dl, cl, rs, dc, rl, mv, lbl, gap, doneSeen;

    $display("[TB] start");
    repeat (3) waitCycle();
    checkOutput("rst cs",    32'(mCs),    32'h1);
    checkOutput("rst sclk",  32'(mSclk),  32'h0);
    checkOutput("rst mosi",  32'(mMosi),  32'h0);
    checkOutput("rst ready", 32'(mReady), 32'h1);
    checkOutput("rst done",  32'(mDone),  32'h0);
    checkOutput("rst dout",  32'(mDout),  32'h00);
    reset = 1'b0;
    repeat (2) waitCycle();

    // Loopback 0xA5 <-> 0x3C with default timing.
    applyStimulus(8'hA5, 8'h3C, 0, fr, dl, cl, rs, dc, rl, mv);
    checkOutput("A5 masterRx",  32'(mDout),  32'h3C);
    checkOutput("A5 slaveRx",   32'(mSlvRx), 32'hA5);
    checkOutput("A5 firstRise", fr, 32'd9);
    checkOutput("A5 doneLbl",   dl, 32'd73);
    checkOutput("A5 csLow",     cl, 32'd72);
    checkOutput("A5 rises",     rs, 32'd8);
    checkOutput("A5 doneCnt",   dc, 32'd1);
    checkOutput("A5 readyLbl",  rl, 32'd77);
    checkOutput("A5 mosiViol",  mv, 32'd0);

    // Single set bit: MOSI high only for bit 0.
    waitReady();
    applyStimulus(8'h01, 8'h80, 0, fr, dl, cl, rs, dc, rl, mv);
    checkOutput("01 slaveRx",  32'(mSlvRx), 32'h01);
    checkOutput("01 masterRx", 32'(mDout),  32'h80);
    checkOutput("01 rises",    rs, 32'd8);
    checkOutput("01 mosiViol", mv, 32'd0);

    // Second start pulse 10 cycles in is ignored.
    waitReady();
    applyStimulus(8'h5C, 8'hE7, 10, fr, dl, cl, rs, dc, rl, mv);
    checkOutput("pulse doneCnt",  dc, 32'd1);
    checkOutput("pulse readyLbl", rl, 32'd77);
    checkOutput("pulse masterRx", 32'(mDout), 32'hE7);
    repeat (3) waitCycle();
    checkOutput("pulse notQueued cs",    32'(mCs),    32'h1);
    checkOutput("pulse notQueued ready", 32'(mReady), 32'h1);

    // Reset during HIGH of bit 4 (labels 41..44).
    slaveTx = 8'h99;
    dataIn  = 8'hF0;
    start   = 1'b1;
    waitCycle();
    start = 1'b0;
    lbl = 1;
    doneSeen = 0;
    while (lbl < 42) begin
      waitCycle();
      lbl++;
      if (mDone) doneSeen++;
    end
    checkOutput("rstMid inHigh", 32'(mSclk), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("rstMid cs",   32'(mCs),   32'h1);
    checkOutput("rstMid sclk", 32'(mSclk), 32'h0);
    checkOutput("rstMid dout", 32'(mDout), 32'h00);
    waitCycle();
    reset = 1'b0;
    repeat (5) begin
      waitCycle();
      if (mDone) doneSeen++;
    end
    checkOutput("rstMid noDone", doneSeen, 32'd0);
    waitReady();
    applyStimulus(8'hFF, 8'h81, 0, fr, dl, cl, rs, dc, rl, mv);
    checkOutput("FF masterRx", 32'(mDout),  32'h81);
    checkOutput("FF slaveRx",  32'(mSlvRx), 32'hFF);
    checkOutput("FF doneLbl",  dl, 32'd73);

    // start held high: two back-to-back transfers.
    waitReady();
    slaveTx = 8'h56;
    dataIn  = 8'h12;
    start   = 1'b1;
    waitCycle();
    dataIn = 8'h34;
    waitDone();
    checkOutput("b2b first masterRx", 32'(mDout),  32'h56);
    checkOutput("b2b first slaveRx",  32'(mSlvRx), 32'h12);
    slaveTx = 8'h78;
    gap = 1;
    while (mCs && gap < 100) begin
      waitCycle();
      if (mCs) gap++;
    end
    checkOutput("b2b csHighGap", 32'(gap >= CG_A + 1 && gap < 100), 32'h1);
    waitDone();
    start = 1'b0;
    checkOutput("b2b second masterRx", 32'(mDout),  32'h78);
    checkOutput("b2b second slaveRx",  32'(mSlvRx), 32'h34);

    // Fast instance: SCLK_HALF=2, CS_GUARD=3.
    sel = 1'b1;
    waitReady();
    applyStimulus(8'hC3, 8'h5A, 0, fr, dl, cl, rs, dc, rl, mv);
    checkOutput("B C3 masterRx",  32'(mDout),  32'h5A);
    checkOutput("B C3 slaveRx",   32'(mSlvRx), 32'hC3);
    checkOutput("B C3 csLow",     cl, 32'd38);
    checkOutput("B C3 firstRise", fr, 32'd6);
    checkOutput("B C3 doneLbl",   dl, 32'd39);
    checkOutput("B C3 rises",     rs, 32'd8);
    waitReady();
    applyStimulus(8'h5A, 8'hC3, 0, fr, dl, cl, rs, dc, rl, mv);
    checkOutput("B 5A masterRx", 32'(mDout),  32'hC3);
    checkOutput("B 5A slaveRx",  32'(mSlvRx), 32'h5A);
    checkOutput("B 5A csLow",    cl, 32'd38);
    checkOutput("B 5A mosiViol", mv, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
